// File: rtl/fp_addsub_resp.sv
// Word-serial modular add/subtract responder.
// Collects a tagged packet of DIV beats carrying words of a and b (least significant first),
// computes (a + b) mod P or (a - b) mod P with a single correction step, and returns the
// result as DIV beats with the request tag echoed.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   op_dat              [0 +: ARITH_BITS] = word of a, [ARITH_BITS +: ARITH_BITS] = word of b
//   op_val/sop/eop/ctl  request beat handshake, framing and tag
//   op_rdy              request accept (high only while collecting)
//   res_dat             result word
//   res_val/sop/eop/err result handshake, framing and framing-error flag
//   res_ctl             echoed request tag
//   res_rdy             downstream accept
module fp_addsub_resp #(
  parameter int unsigned          ELEM_BITS  = 256,
  parameter int unsigned          ARITH_BITS = 64,
  parameter int unsigned          CTL_BITS   = 8,
  parameter bit                   SUB        = 1'b0,
  parameter logic [ELEM_BITS-1:0] P          =
      ELEM_BITS'(256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*ARITH_BITS-1:0] op_dat,
  input  logic                    op_val,
  input  logic                    op_sop,
  input  logic                    op_eop,
  input  logic [CTL_BITS-1:0]     op_ctl,
  output logic                    op_rdy,
  output logic [ARITH_BITS-1:0]   res_dat,
  output logic                    res_val,
  output logic                    res_sop,
  output logic                    res_eop,
  output logic                    res_err,
  output logic [CTL_BITS-1:0]     res_ctl,
  input  logic                    res_rdy
);

  localparam int unsigned DIV  = ELEM_BITS / ARITH_BITS;
  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {StCollect, StCalc, StSel, StOut} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ELEM_BITS-1:0]   a_q, a_d, b_q, b_d;
  logic [ELEM_BITS-1:0]   r0_q, r0_d, r1_q, r1_d;
  logic [ELEM_BITS-1:0]   sh_q, sh_d;
  // c0: carry/borrow of the a +/- b chain; c1: carry/borrow of the +/- P chain
  logic                   c0_q, c0_d, c1_q, c1_d;
  logic [CTL_BITS-1:0]    ctl_q, ctl_d, oct_q, oct_d;
  logic                   err_q, err_d;
  logic                   val_q, val_d, sop_q, sop_d, eop_q, eop_d, oerr_q, oerr_d;

  logic [ARITH_BITS-1:0]  a_w, b_w, p_w;
  logic [ARITH_BITS:0]    s0, s1;
  logic                   use_r1;

  assign op_rdy  = (state_q == StCollect);
  assign res_dat = sh_q[ARITH_BITS-1:0];
  assign res_val = val_q;
  assign res_sop = sop_q;
  assign res_eop = eop_q;
  assign res_err = oerr_q;
  assign res_ctl = oct_q;

  assign a_w = a_q[int'(cnt_q)*ARITH_BITS +: ARITH_BITS];
  assign b_w = b_q[int'(cnt_q)*ARITH_BITS +: ARITH_BITS];
  assign p_w = P[int'(cnt_q)*ARITH_BITS +: ARITH_BITS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    sh_d    = sh_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    ctl_d   = ctl_q;
    oct_d   = oct_q;
    err_d   = err_q;
    val_d   = val_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    oerr_d  = oerr_q;
    s0      = '0;
    s1      = '0;
    use_r1  = 1'b0;

    unique case (state_q)
      StCollect: begin
        if (op_val) begin
          for (int j = 0; j < int'(DIV); j++) begin
            if (CW'(j) == cnt_q) begin
              a_d[j*ARITH_BITS +: ARITH_BITS] = op_dat[0 +: ARITH_BITS];
              b_d[j*ARITH_BITS +: ARITH_BITS] = op_dat[ARITH_BITS +: ARITH_BITS];
            end else if (op_eop && (CW'(j) > cnt_q)) begin
              // early eop: words never sent are taken as zero
              a_d[j*ARITH_BITS +: ARITH_BITS] = '0;
              b_d[j*ARITH_BITS +: ARITH_BITS] = '0;
            end
          end
          if (cnt_q == '0) begin
            ctl_d = op_ctl;
          end
          if ((op_sop != (cnt_q == '0)) || (op_eop != (cnt_q == LAST))) begin
            err_d = 1'b1;
          end
          if (op_eop || (cnt_q == LAST)) begin
            state_d = StCalc;
            cnt_d   = '0;
            c0_d    = 1'b0;
            c1_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      StCalc: begin
        if (!SUB) begin
          s0 = {1'b0, a_w} + {1'b0, b_w} + (ARITH_BITS+1)'(c0_q);
          s1 = {1'b0, s0[ARITH_BITS-1:0]} - {1'b0, p_w} - (ARITH_BITS+1)'(c1_q);
        end else begin
          s0 = {1'b0, a_w} - {1'b0, b_w} - (ARITH_BITS+1)'(c0_q);
          s1 = {1'b0, s0[ARITH_BITS-1:0]} + {1'b0, p_w} + (ARITH_BITS+1)'(c1_q);
        end
        c0_d = s0[ARITH_BITS];
        c1_d = s1[ARITH_BITS];
        r0_d[int'(cnt_q)*ARITH_BITS +: ARITH_BITS] = s0[ARITH_BITS-1:0];
        r1_d[int'(cnt_q)*ARITH_BITS +: ARITH_BITS] = s1[ARITH_BITS-1:0];
        if (cnt_q == LAST) begin
          state_d = StSel;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      StSel: begin
        // add: a + b >= P when the sum overflowed or sum - P did not borrow
        // sub: a - b borrowed, so add P back
        use_r1  = SUB ? c0_q : (c0_q || !c1_q);
        sh_d    = use_r1 ? r1_q : r0_q;
        val_d   = 1'b1;
        sop_d   = 1'b1;
        eop_d   = (LAST == '0);
        oct_d   = ctl_q;
        oerr_d  = err_q;
        cnt_d   = '0;
        state_d = StOut;
      end

      StOut: begin
        if (res_rdy) begin
          sh_d  = sh_q >> ARITH_BITS;
          sop_d = 1'b0;
          if (cnt_q == LAST) begin
            val_d   = 1'b0;
            eop_d   = 1'b0;
            oerr_d  = 1'b0;
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = StCollect;
          end else begin
            cnt_d = cnt_q + CW'(1);
            eop_d = ((cnt_q + CW'(1)) == LAST);
          end
        end
      end

      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StCollect;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      sh_q    <= '0;
      c0_q    <= 1'b0;
      c1_q    <= 1'b0;
      ctl_q   <= '0;
      oct_q   <= '0;
      err_q   <= 1'b0;
      val_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      sh_q    <= sh_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      ctl_q   <= ctl_d;
      oct_q   <= oct_d;
      err_q   <= err_d;
      val_q   <= val_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      oerr_q  <= oerr_d;
    end
  end

endmodule
